// File: rtl/sipo_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_collector
//  Description : Serial-in parallel-out deserializer for the serial adder
//                datapath. Collects an LSB-first serial stream one bit per
//                qualified clock, assembles WIDTH-bit words and presents each
//                completed word on a registered parallel output guarded by a
//                valid/ack handshake. Receive-side counterpart of the
//                parallel-in serial-out operand loader.
//
//  Parameters  :
//    WIDTH      word length in bits (>= 2)
//    CW         bit counter width, $clog2(WIDTH)+1
//
//  Ports       :
//    clk        in   1      rising-edge clock
//    reset_n    in   1      synchronous active-low reset
//    clear      in   1      synchronous abort of the partial word; clears overrun
//    shift      in   1      qualifies d_in for capture this cycle
//    d_in       in   1      serial data bit, LSB first
//    ack        in   1      consumer accepts the word on d_out
//    d_out      out  WIDTH  last completed word
//    valid      out  1      d_out holds an unacknowledged word
//    busy       out  1      partial word in progress (bit_count != 0)
//    bit_count  out  CW     bits collected toward the current word
//    overrun    out  1      sticky: a word completed over an unacknowledged one
//
//  Revision    : 1.0  initial release
// ============================================================================
module sipo_collector #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             d_in,
  input  logic             ack,
  output logic [WIDTH-1:0] d_out,
  output logic             valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  // Counter value at which the next shift completes a word.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             capture;
  logic             word_done;
  logic [CW-1:0]    count_next;

  // A clear in the same cycle as shift wins, so the bit is dropped.
  assign capture    = shift && !clear;
  assign word_done  = capture && (bit_count == LAST_BIT);

  // New bit enters at the top and moves down, so the first bit received
  // ends up at bit 0 after WIDTH shifts.
  assign sr_shifted = {d_in, sr[WIDTH-1:1]};

  always_comb begin
    count_next = bit_count;
    if (clear) begin
      count_next = '0;
    end else if (capture) begin
      if (word_done) begin
        count_next = '0;
      end else begin
        count_next = bit_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr        <= '0;
      bit_count <= '0;
      busy      <= 1'b0;
      d_out     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bit_count <= count_next;
      // busy is registered from the next count so it tracks bit_count exactly.
      busy      <= (count_next != '0);

      if (clear) begin
        sr <= '0;
      end else if (capture) begin
        sr <= sr_shifted;
      end

      if (clear) begin
        overrun <= 1'b0;
      end else if (word_done && valid && !ack) begin
        // Previous word was never taken; it is lost.
        overrun <= 1'b1;
      end

      if (word_done) begin
        // A completing word always leaves valid high, even when ack retires
        // the previous word on this same edge.
        d_out <= sr_shifted;
        valid <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sipo_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_collector
//  Description : Directed self-checking bench for sipo_collector (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_collector;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             shift;
  logic             d_in;
  logic             ack;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             overrun;

  int compared   = 0;
  int mismatched = 0;

  sipo_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .shift     (shift),
    .d_in      (d_in),
    .ack       (ack),
    .d_out     (d_out),
    .valid     (valid),
    .busy      (busy),
    .bit_count (bit_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, settle 1 time unit, return to idle.
  task automatic cyc(input logic s, input logic d, input logic a,
                     input logic c, input logic r);
    shift = s; d_in = d; ack = a; clear = c; reset_n = r;
    @(posedge clk);
    #1;
    shift = 1'b0; d_in = 1'b0; ack = 1'b0; clear = 1'b0; reset_n = 1'b1;
  endtask

  // Stream a nibble LSB first on consecutive cycles; optionally ack on the last.
  task automatic send_word(input logic [3:0] w, input logic ack_last);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, w[i], (i == 3) ? ack_last : 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_dout, input logic e_valid,
                         input logic e_busy, input logic [CW-1:0] e_cnt, input logic e_ovr);
    chk({tag, ".d_out"},     32'(d_out),     32'(e_dout));
    chk({tag, ".valid"},     32'(valid),     32'(e_valid));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    chk({tag, ".bit_count"}, 32'(bit_count), 32'(e_cnt));
    chk({tag, ".overrun"},   32'(overrun),   32'(e_ovr));
  endtask

  initial begin
    shift = 1'b0; d_in = 1'b0; ack = 1'b0; clear = 1'b0; reset_n = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("reset", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Basic word: 1,0,1,1 -> 1101
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("basic.cnt1", 32'(bit_count), 32'd1);
    chk("basic.busy1", 32'(busy), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("basic.valid_pre", 32'(valid), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("basic", 4'b1101, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("basic.ack", 4'b1101, 1'b0, 1'b0, 3'd0, 1'b0);
    // ack while nothing is pending is ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle_ack.valid", 32'(valid), 32'd0);

    // Gapped input: 0,1,1,0 with two idle cycles after each shift
    begin
      logic [3:0] g = 4'b0110;
      logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, g[i], 1'b0, 1'b0, 1'b1);
        chk($sformatf("gap.cnt_shift%0d", i), 32'(bit_count), 32'(exp_cnt[i]));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk($sformatf("gap.cnt_hold%0d", i), 32'(bit_count), 32'(exp_cnt[i]));
      end
    end
    chk_all("gap", 4'b0110, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-to-back 0xA then 0x5, ack on the completing cycle of the 2nd word
    send_word(4'hA, 1'b0);
    chk_all("b2b.first", 4'hA, 1'b1, 1'b0, 3'd0, 1'b0);
    send_word(4'h5, 1'b1);
    chk_all("b2b.second", 4'h5, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b.ack", 32'(valid), 32'd0);

    // Overrun: 0x3 then 0xC with no ack; clear drops only overrun
    send_word(4'h3, 1'b0);
    send_word(4'hC, 1'b0);
    chk_all("ovr", 4'hC, 1'b1, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("ovr.clear", 4'hC, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr.ack", 32'(valid), 32'd0);

    // Abort priority: 2 bits, then clear+shift together drops the bit
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort.cnt2", 32'(bit_count), 32'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("abort.clear", 4'hC, 1'b0, 1'b0, 3'd0, 1'b0);
    send_word(4'b0111, 1'b0);
    chk_all("abort.word", 4'b0111, 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset mid-word: 3 bits, then reset (shift asserted too) clears everything
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst.cnt3", 32'(bit_count), 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("rst.mid", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    send_word(4'b1001, 1'b0);
    chk_all("rst.word", 4'b1001, 1'b1, 1'b0, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_collector.md
# sipo_collector

Serial-in parallel-out deserializer for the serial adder datapath. Shifts in the LSB-first serial sum stream one bit per qualified clock, assembles WIDTH-bit words, and presents each completed word on a registered parallel output with a valid/ack handshake. It is the receive-side counterpart of the parallel-in serial-out loader that feeds the adder operands.

## Interface

- WIDTH, 4, word length in bits (≥2); count register width CW = $clog2(WIDTH)+1
- clk  input  1  rising-edge clock, single clock domain
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- clear  input  1  synchronous abort: discards partial word, clears overrun
- shift  input  1  qualifies d_in for capture this cycle
- d_in  input  1  serial data bit, LSB first
- ack  input  1  consumer accepts current d_out word
- d_out  output  WIDTH  last completed word, registered
- valid  output  1  d_out holds an unacknowledged word
- busy  output  1  partial word in progress (bit_count ≠ 0)
- bit_count  output  CW  bits collected toward current word, 0..WIDTH-1
- overrun  output  1  sticky: a word completed while the previous was unacknowledged

## Operation

- Internal shift register sr[WIDTH-1:0]; on shift: sr <= {d_in, sr[WIDTH-1:1]} (first bit ends at bit 0).
- bit_count increments on each shift; shift with bit_count == WIDTH-1 is the completing shift.
- Completing shift: d_out <= {d_in, sr[WIDTH-1:1]}, valid <= 1, bit_count <= 0 (wrap); sr contents irrelevant after.
- Shift pulses need not be contiguous; idle cycles (shift=0) hold sr and bit_count.
- States implied by bit_count: IDLE (0, busy=0) -> COLLECT (1..WIDTH-1, busy=1) -> back to IDLE on completing shift.
- Handshake: valid stays 1 until a cycle with ack=1; ack while valid=0 is ignored.
- Completing shift while valid=1 and ack=0: d_out overwritten with new word, valid stays 1, overrun <= 1.
- Completing shift with ack=1 same cycle: new word loads, valid stays 1, overrun unchanged.
- clear: bit_count <= 0, sr <= 0, overrun <= 0; d_out and valid unaffected. clear has priority over shift (bit dropped).
- reset_n=0: all state cleared regardless of other inputs.

## Timing

- Reset values: d_out = 0, valid = 0, busy = 0, bit_count = 0, overrun = 0; sr = 0.
- All outputs registered; updates visible the cycle after the triggering clock edge's inputs are sampled.
- Latency: valid rises on the edge of the WIDTH-th shift; word readable the following cycle.
- Back-to-back words: WIDTH consecutive shift cycles per word, no dead cycle required between words.
- ack deasserts valid on the same edge it is sampled; consumer sees valid=0 next cycle.
- Reset mid-word: partial bits discarded; next word starts at bit 0 after reset_n returns high.
- clear mid-word: same as reset for sr/bit_count only; pending valid word remains available.

## Test plan

- Basic word (WIDTH=4): shift bits 1,0,1,1 on 4 consecutive cycles -> d_out=4'b1101, valid=1 after 4th edge, bit_count=0, busy=0; ack 1 cycle -> valid=0.
- Gapped input: bits 0,1,1,0 with 2 idle cycles between each -> d_out=4'b0110, bit_count steps 1,2,3,0 only on shift cycles.
- Back-to-back with ack: 0xA then 0x5 streamed in 8 consecutive cycles, ack on the cycle the 2nd word completes -> d_out=0x5, valid=1, overrun=0.
- Overrun: 0x3 then 0xC with no ack -> d_out=0xC, valid=1, overrun=1; clear -> overrun=0, d_out=0xC, valid=1.
- Abort priority: shift 2 bits, then clear and shift same cycle -> bit_count=0, busy=0; next 4 bits 1,1,1,0 -> d_out=4'b0111.
- Reset mid-word: shift 3 bits, reset_n=0 one cycle -> all outputs 0; then 4 bits 1,0,0,1 -> d_out=4'b1001.
